warn_monitor: RTL and testbench



---
 rtl/warn_monitor.sv | 137 +++++++++++++
 tb/tb_warn_monitor.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/warn_monitor.sv
// Multi-channel low-level warning monitor: per-channel debounce, hysteresis
// and optional sticky latching against a shared signed warn level.
`timescale 1ns/1ps
module warn_monitor #(
  parameter int NCH      = 4,
  parameter int WIDTH    = 32,
  parameter int DEBOUNCE = 3
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NCH*WIDTH-1:0] values,
  input  logic [WIDTH-1:0]     warn_level,
  input  logic [WIDTH-1:0]     hysteresis,
  input  logic                 sticky_mode,
  input  logic [NCH-1:0]       clear,
  output logic [NCH-1:0]       warn,
  output logic [NCH-1:0]       warn_rise,
  output logic                 any_warn
);

  localparam int CW = $clog2(DEBOUNCE + 1);
  localparam logic [CW-1:0] DEB  = CW'(DEBOUNCE);
  localparam logic [CW-1:0] ONE  = CW'(1);
  localparam logic [CW-1:0] ZERO = '0;

  typedef enum logic [1:0] {S_OK, S_ARMING, S_WARN, S_RELEASING} state_t;

  function automatic logic is_low(input logic signed [WIDTH-1:0] v,
                                  input logic signed [WIDTH-1:0] lvl);
    return v < lvl;
  endfunction

  // Threshold is formed two bits wider so level + unsigned margin never wraps.
  function automatic logic is_rec(input logic signed [WIDTH-1:0] v,
                                  input logic signed [WIDTH-1:0] lvl,
                                  input logic [WIDTH-1:0]        hys);
    return $signed({{2{v[WIDTH-1]}}, v}) >=
           ($signed({{2{lvl[WIDTH-1]}}, lvl}) + $signed({2'b00, hys}));
  endfunction

  state_t          state     [NCH];
  logic [CW-1:0]   cnt       [NCH];
  state_t          nxt_state [NCH];
  logic [CW-1:0]   nxt_cnt   [NCH];
  logic [CW-1:0]   cnt_inc   [NCH];
  logic [NCH-1:0]  low;
  logic [NCH-1:0]  rec;
  logic [NCH-1:0]  nxt_warn;

  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      nxt_state[i] = state[i];
      nxt_cnt[i]   = cnt[i];
      cnt_inc[i]   = cnt[i] + ONE;
      low[i]       = is_low(values[i*WIDTH +: WIDTH], warn_level);
      rec[i]       = is_rec(values[i*WIDTH +: WIDTH], warn_level, hysteresis);
      case (state[i])
        S_OK: begin
          if (low[i]) begin
            if (DEBOUNCE == 1) begin
              nxt_state[i] = S_WARN;
              nxt_cnt[i]   = ZERO;
            end else begin
              nxt_state[i] = S_ARMING;
              nxt_cnt[i]   = ONE;
            end
          end
        end
        S_ARMING: begin
          if (!low[i]) begin
            nxt_state[i] = S_OK;
            nxt_cnt[i]   = ZERO;
          end else if (cnt_inc[i] == DEB) begin
            nxt_state[i] = S_WARN;
            nxt_cnt[i]   = ZERO;
          end else begin
            nxt_cnt[i]   = cnt_inc[i];
          end
        end
        S_WARN: begin
          if (sticky_mode) begin
            // A latched warning only clears once the reading is no longer low.
            if (clear[i] && !low[i]) begin
              nxt_state[i] = S_OK;
              nxt_cnt[i]   = ZERO;
            end
          end else if (rec[i]) begin
            if (DEBOUNCE == 1) begin
              nxt_state[i] = S_OK;
              nxt_cnt[i]   = ZERO;
            end else begin
              nxt_state[i] = S_RELEASING;
              nxt_cnt[i]   = ONE;
            end
          end
        end
        S_RELEASING: begin
          if (sticky_mode || !rec[i]) begin
            nxt_state[i] = S_WARN;
            nxt_cnt[i]   = ZERO;
          end else if (cnt_inc[i] == DEB) begin
            nxt_state[i] = S_OK;
            nxt_cnt[i]   = ZERO;
          end else begin
            nxt_cnt[i]   = cnt_inc[i];
          end
        end
        default: begin
          nxt_state[i] = S_OK;
          nxt_cnt[i]   = ZERO;
        end
      endcase
      nxt_warn[i] = (nxt_state[i] == S_WARN) || (nxt_state[i] == S_RELEASING);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < NCH; i++) begin
        state[i] <= S_OK;
        cnt[i]   <= ZERO;
      end
      warn      <= '0;
      warn_rise <= '0;
      any_warn  <= 1'b0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        state[i] <= nxt_state[i];
        cnt[i]   <= nxt_cnt[i];
      end
      warn      <= nxt_warn;
      warn_rise <= nxt_warn & ~warn;
      any_warn  <= |nxt_warn;
    end
  end

endmodule

// File: tb/tb_warn_monitor.sv
// Scenario bench for warn_monitor: a cycle model feeds a scoreboard queue,
// and each scenario task adds its own targeted checks.
`timescale 1ns/1ps
module tb_warn_monitor;

  localparam int NCH = 4;
  localparam int W   = 32;
  localparam int DEB = 3;

  logic             clock;
  logic             reset;
  logic [NCH*W-1:0] values;
  logic [W-1:0]     warn_level;
  logic [W-1:0]     hysteresis;
  logic             sticky_mode;
  logic [NCH-1:0]   clear;
  logic [NCH-1:0]   warn;
  logic [NCH-1:0]   warn_rise;
  logic             any_warn;

  int checks = 0;
  int errors = 0;

  logic [8:0]     exp_q[$];
  logic [8:0]     sb_exp;
  logic [NCH-1:0] m_warn;
  int             m_run [NCH];

  warn_monitor #(.NCH(NCH), .WIDTH(W), .DEBOUNCE(DEB)) dut (
    .clock(clock), .reset(reset), .values(values), .warn_level(warn_level),
    .hysteresis(hysteresis), .sticky_mode(sticky_mode), .clear(clear),
    .warn(warn), .warn_rise(warn_rise), .any_warn(any_warn)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
    $fatal(1, "watchdog");
  end

  always @(negedge clock) begin
    if (exp_q.size() > 0) begin
      sb_exp = exp_q.pop_front();
      checks++;
      if ({warn, warn_rise, any_warn} !== sb_exp) begin
        errors++;
        $display("FAIL scoreboard t=%0t got warn=%b rise=%b any=%b want warn=%b rise=%b any=%b",
                 $time, warn, warn_rise, any_warn, sb_exp[8:5], sb_exp[4:1], sb_exp[0]);
      end
    end
  end

  task automatic set_ch(input int ch, input logic [W-1:0] v);
    values[ch*W +: W] = v;
  endtask

  // Advance one clock: predict the post-edge outputs from the current inputs.
  task automatic tick();
    logic [NCH-1:0] nw;
    nw = m_warn;
    for (int i = 0; i < NCH; i++) begin
      longint v, lv, hv;
      bit lo, rc;
      v  = longint'($signed(values[i*W +: W]));
      lv = longint'($signed(warn_level));
      hv = longint'({32'd0, hysteresis});
      lo = v < lv;
      rc = v >= lv + hv;
      if (!reset) begin
        nw[i] = 1'b0;
        m_run[i] = 0;
      end else if (!m_warn[i]) begin
        m_run[i] = lo ? m_run[i] + 1 : 0;
        if (m_run[i] == DEB) begin nw[i] = 1'b1; m_run[i] = 0; end
      end else if (sticky_mode) begin
        if (m_run[i] == 0 && clear[i] && !lo) nw[i] = 1'b0;
        m_run[i] = 0;
      end else begin
        m_run[i] = rc ? m_run[i] + 1 : 0;
        if (m_run[i] == DEB) begin nw[i] = 1'b0; m_run[i] = 0; end
      end
    end
    if (!reset) exp_q.push_back(9'd0);
    else        exp_q.push_back({nw, nw & ~m_warn, |nw});
    m_warn = nw;
    @(posedge clock);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic all_ch(input logic [W-1:0] v);
    for (int i = 0; i < NCH; i++) set_ch(i, v);
  endtask

  task automatic test_reset();
    all_ch(32'd30);
    reset = 1'b0;
    ticks(5);
    checks++;
    if ({warn, warn_rise, any_warn} !== 9'd0) begin
      errors++;
      $display("FAIL reset_state got %b want %b", {warn, warn_rise, any_warn}, 9'd0);
    end
    reset = 1'b1;
    set_ch(0, 32'd9);
    ticks(2);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    ticks(2);
    checks++;
    if (warn[0] !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_arming got warn0=%b want 0", warn[0]);
    end
    set_ch(0, 32'd30);
    tick();
  endtask

  task automatic test_entry();
    set_ch(0, 32'd9);
    ticks(3);
    checks++;
    if ({warn[0], warn_rise[0], any_warn} !== 3'b111) begin
      errors++;
      $display("FAIL entry_edge got warn0/rise0/any=%b want 111", {warn[0], warn_rise[0], any_warn});
    end
    tick();
    checks++;
    if ({warn[0], warn_rise[0]} !== 2'b10) begin
      errors++;
      $display("FAIL entry_rise_once got warn0/rise0=%b want 10", {warn[0], warn_rise[0]});
    end
    set_ch(0, 32'd30);
    ticks(3);
    checks++;
    if (warn[0] !== 1'b0) begin
      errors++;
      $display("FAIL entry_release got warn0=%b want 0", warn[0]);
    end
    set_ch(0, 32'd9);  ticks(2);
    set_ch(0, 32'd10); tick();
    set_ch(0, 32'd9);  ticks(2);
    checks++;
    if (warn[0] !== 1'b0) begin
      errors++;
      $display("FAIL entry_broken_run got warn0=%b want 0", warn[0]);
    end
    set_ch(0, 32'd30);
    tick();
  endtask

  task automatic test_hysteresis();
    set_ch(0, 32'd9);
    ticks(3);
    set_ch(0, 32'd11);
    ticks(10);
    checks++;
    if (warn[0] !== 1'b1) begin
      errors++;
      $display("FAIL hyst_band_hold got warn0=%b want 1", warn[0]);
    end
    set_ch(0, 32'd12);
    ticks(3);
    checks++;
    if (warn[0] !== 1'b0) begin
      errors++;
      $display("FAIL hyst_recover got warn0=%b want 0", warn[0]);
    end
    set_ch(0, 32'd9);
    ticks(3);
    set_ch(0, 32'd12); ticks(2);
    set_ch(0, 32'd11); tick();
    checks++;
    if (warn[0] !== 1'b1) begin
      errors++;
      $display("FAIL hyst_abort_release got warn0=%b want 1", warn[0]);
    end
    set_ch(0, 32'd30);
    ticks(3);
  endtask

  task automatic test_sticky();
    sticky_mode = 1'b1;
    set_ch(1, -32'sd5);
    ticks(3);
    checks++;
    if (warn[1] !== 1'b1) begin
      errors++;
      $display("FAIL sticky_enter got warn1=%b want 1", warn[1]);
    end
    set_ch(1, 32'd30);
    ticks(20);
    checks++;
    if (warn[1] !== 1'b1) begin
      errors++;
      $display("FAIL sticky_hold got warn1=%b want 1", warn[1]);
    end
    set_ch(1, 32'd5);
    clear = 4'b0010;
    tick();
    clear = 4'b0000;
    checks++;
    if (warn[1] !== 1'b1) begin
      errors++;
      $display("FAIL sticky_clear_while_low got warn1=%b want 1", warn[1]);
    end
    set_ch(1, 32'd30);
    clear = 4'b0010;
    tick();
    clear = 4'b0000;
    checks++;
    if (warn[1] !== 1'b0) begin
      errors++;
      $display("FAIL sticky_clear got warn1=%b want 0", warn[1]);
    end
    sticky_mode = 1'b0;
  endtask

  task automatic test_extremes();
    set_ch(3, 32'd9);
    ticks(3);
    warn_level = 32'h7fff_ffff;
    hysteresis = 32'h7fff_ffff;
    set_ch(0, 32'h7fff_ffff);
    set_ch(1, 32'h7fff_ffff);
    set_ch(2, 32'h8000_0000);
    set_ch(3, 32'h7fff_ffff);
    ticks(3);
    checks++;
    if ({warn, warn_rise} !== 8'b1100_0100) begin
      errors++;
      $display("FAIL extremes_entry got warn=%b rise=%b want warn=1100 rise=0100", warn, warn_rise);
    end
    ticks(5);
    checks++;
    if (warn !== 4'b1100) begin
      errors++;
      $display("FAIL extremes_no_wrap got warn=%b want 1100", warn);
    end
    warn_level = 32'd10;
    hysteresis = 32'd2;
    all_ch(32'd30);
    ticks(3);
    checks++;
    if (warn !== 4'b0000) begin
      errors++;
      $display("FAIL extremes_restore got warn=%b want 0000", warn);
    end
  endtask

  task automatic test_mode_switch();
    sticky_mode = 1'b0;
    set_ch(0, 32'd9);
    ticks(3);
    set_ch(0, 32'd12);
    ticks(2);
    sticky_mode = 1'b1;
    tick();
    checks++;
    if (warn[0] !== 1'b1) begin
      errors++;
      $display("FAIL mode_switch_edge got warn0=%b want 1", warn[0]);
    end
    ticks(4);
    checks++;
    if (warn[0] !== 1'b1) begin
      errors++;
      $display("FAIL mode_switch_latched got warn0=%b want 1", warn[0]);
    end
    sticky_mode = 1'b0;
    ticks(3);
    checks++;
    if (warn[0] !== 1'b0) begin
      errors++;
      $display("FAIL mode_switch_release got warn0=%b want 0", warn[0]);
    end
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 300; n++) begin
      for (int i = 0; i < NCH; i++) set_ch(i, 32'(5 + $urandom_range(0, 10)));
      if (n % 40 == 0) sticky_mode = $urandom_range(0, 1) == 1;
      clear = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
      reset = (n == 150) ? 1'b0 : 1'b1;
      tick();
    end
    reset = 1'b1;
    clear = 4'b0000;
    sticky_mode = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    values = '0;
    warn_level = 32'd10;
    hysteresis = 32'd2;
    sticky_mode = 1'b0;
    clear = '0;
    m_warn = '0;
    for (int i = 0; i < NCH; i++) m_run[i] = 0;
    test_reset();
    test_entry();
    test_hysteresis();
    test_sticky();
    test_extremes();
    test_mode_switch();
    test_back_to_back();
    repeat (3) @(negedge clock);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d pending want 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
